// File: rtl/change_pkg.sv
// Shared FSM state codes, coin denominations and coin-select encoding
// for the change dispenser.
package change_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_EJECT  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  // Denominations in 5-cent units
  localparam int DEN_N = 1;
  localparam int DEN_D = 2;
  localparam int DEN_Q = 5;

  typedef enum logic [1:0] {COIN_NONE, COIN_N, COIN_D, COIN_Q} coin_e;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: largest denomination that fits the remaining amount
// and is still in stock.
module change_coin_select
  import change_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic             has_n,
  input  logic             has_d,
  input  logic             has_q,
  output coin_e            coin,
  output logic [AMT_W-1:0] denom
);

  always_comb begin
    coin  = COIN_NONE;
    denom = '0;
    if (remaining >= AMT_W'(DEN_Q) && has_q) begin
      coin  = COIN_Q;
      denom = AMT_W'(DEN_Q);
    end else if (remaining >= AMT_W'(DEN_D) && has_d) begin
      coin  = COIN_D;
      denom = AMT_W'(DEN_D);
    end else if (remaining >= AMT_W'(DEN_N) && has_n) begin
      coin  = COIN_N;
      denom = AMT_W'(DEN_N);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays a request coin by coin over an eject/ack
// handshake. Define CHANGE_TIMEOUT_EN to add the hopper timeout fault.
//
// state  | meaning
// IDLE   | waiting for a request, inventory may be loaded
// SELECT | pick next coin (or finish)
// EJECT  | eject_* held until hopper_ack
// DONE   | one-cycle completion report
// FAULT  | hopper timeout, left only by reset
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int INV_W       = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             eject_n,
  output logic             eject_d,
  output logic             eject_q,
  input  logic             hopper_ack,
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv_n_in,
  input  logic [INV_W-1:0] inv_d_in,
  input  logic [INV_W-1:0] inv_q_in,
  output logic [INV_W-1:0] inv_n,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_q,
  output logic             busy,
  output logic             done,
  output logic             done_short,
  output logic [AMT_W-1:0] short_amount,
  output logic             fault
);

  logic [2:0]       state;
  logic [AMT_W-1:0] remaining;
  coin_e            coin;
  logic [AMT_W-1:0] denom;
  coin_e            pick;
  logic [AMT_W-1:0] pick_denom;

  change_coin_select #(.AMT_W(AMT_W)) u_select (
    .remaining (remaining),
    .has_n     (inv_n != '0),
    .has_d     (inv_d != '0),
    .has_q     (inv_q != '0),
    .coin      (pick),
    .denom     (pick_denom)
  );

`ifdef CHANGE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr;

  // Down-counter armed while selecting so it starts fresh on EJECT entry
  always_ff @(posedge clk) begin
    if (reset)
      tmr <= '0;
    else if (state == ST_SELECT)
      tmr <= TMR_W'(TIMEOUT_CYC - 1);
    else if (state == ST_EJECT && tmr != '0)
      tmr <= tmr - 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      coin      <= COIN_NONE;
      denom     <= '0;
      inv_n     <= '0;
      inv_d     <= '0;
      inv_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inv_load) begin
            inv_n <= inv_n_in;
            inv_d <= inv_d_in;
            inv_q <= inv_q_in;
          end
          if (req_valid) begin
            remaining <= req_amount;
            state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (pick == COIN_NONE) begin
            state <= ST_DONE;
          end else begin
            coin  <= pick;
            denom <= pick_denom;
            state <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (hopper_ack) begin
            remaining <= remaining - denom;
            case (coin)
              COIN_N:  inv_n <= inv_n - 1'b1;
              COIN_D:  inv_d <= inv_d - 1'b1;
              COIN_Q:  inv_q <= inv_q - 1'b1;
              default: ;
            endcase
            state <= ST_SELECT;
          end
`ifdef CHANGE_TIMEOUT_EN
          else if (tmr == '0) begin
            state <= ST_FAULT;
          end
`endif
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign eject_n      = (state == ST_EJECT) && (coin == COIN_N);
  assign eject_d      = (state == ST_EJECT) && (coin == COIN_D);
  assign eject_q      = (state == ST_EJECT) && (coin == COIN_Q);
  assign done         = (state == ST_DONE);
  assign done_short   = done && (remaining != '0);
  assign short_amount = done ? remaining : '0;

`ifdef CHANGE_TIMEOUT_EN
  assign fault = (state == ST_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule
